// File: rtl/dht11_responder.sv
// DHT11 sensor emulator: waits for a host start pulse, answers with the
// 80/80 us response and then sends humidity, temperature and checksum bytes.
module dht11_responder #(
  parameter int START_MIN  = 18000,
  parameter int RESP_DELAY = 30,
  parameter int RESP_LOW   = 80,
  parameter int RESP_HIGH  = 80,
  parameter int BIT_LOW    = 50,
  parameter int BIT0_HIGH  = 26,
  parameter int BIT1_HIGH  = 70
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dht_in,
  output logic       dht_oe,
  input  logic [7:0] hum_int,
  input  logic [7:0] hum_float,
  input  logic [7:0] temp_int,
  input  logic [7:0] temp_float,
  input  logic       bad_checksum,
  output logic       busy,
  output logic       done,
  output logic       short_start
);

  typedef enum logic [3:0] {
    IDLE, HOST_LOW, RESP_WAIT, RESP_LO, RESP_HI, BIT_LO, BIT_HI, END_LO, FINISH
  } state_t;

  localparam logic [14:0] START_MIN_C  = 15'(START_MIN);
  localparam logic [14:0] RESP_DELAY_C = 15'(RESP_DELAY);
  localparam logic [14:0] RESP_LOW_C   = 15'(RESP_LOW);
  localparam logic [14:0] RESP_HIGH_C  = 15'(RESP_HIGH);
  localparam logic [14:0] BIT_LOW_C    = 15'(BIT_LOW);
  localparam logic [14:0] BIT0_HIGH_C  = 15'(BIT0_HIGH);
  localparam logic [14:0] BIT1_HIGH_C  = 15'(BIT1_HIGH);

  function automatic logic [7:0] frame_checksum(input logic [7:0] a, input logic [7:0] b,
                                                input logic [7:0] c, input logic [7:0] d,
                                                input logic flip);
    logic [7:0] sum;
    sum = a + b + c + d;
    return sum ^ {7'b0000000, flip};
  endfunction

  state_t      state_r, state_next_s;
  logic [1:0]  sync_r;
  logic        s_in_s;
  logic [14:0] cnt_r, cnt_next_s;
  logic [5:0]  idx_r, idx_next_s;
  logic [39:0] frame_r;
  logic        latch_s, short_s;

  assign s_in_s = sync_r[1];

  // Two-flop synchronizer for the asynchronous bus level; idles high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_r <= 2'b11;
    else       sync_r <= {sync_r[0], dht_in};
  end

  // Next-state, counter and bit-index logic; timed phases restart the counter at 1.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    idx_next_s   = idx_r;
    latch_s      = 1'b0;
    short_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (!s_in_s) begin
          state_next_s = HOST_LOW;
          cnt_next_s   = 15'd1;
        end else begin
          cnt_next_s   = 15'd0;
        end
      end
      HOST_LOW: begin
        if (!s_in_s) begin
          cnt_next_s = (cnt_r == 15'h7FFF) ? cnt_r : cnt_r + 15'd1;
        end else if (cnt_r >= START_MIN_C) begin
          latch_s      = 1'b1;
          state_next_s = RESP_WAIT;
          cnt_next_s   = 15'd1;
        end else begin
          short_s      = 1'b1;
          state_next_s = IDLE;
          cnt_next_s   = 15'd0;
        end
      end
      RESP_WAIT: begin
        if (cnt_r >= RESP_DELAY_C) begin
          state_next_s = RESP_LO;
          cnt_next_s   = 15'd1;
        end else begin
          cnt_next_s   = cnt_r + 15'd1;
        end
      end
      RESP_LO: begin
        if (cnt_r >= RESP_LOW_C) begin
          state_next_s = RESP_HI;
          cnt_next_s   = 15'd1;
        end else begin
          cnt_next_s   = cnt_r + 15'd1;
        end
      end
      RESP_HI: begin
        if (cnt_r >= RESP_HIGH_C) begin
          state_next_s = BIT_LO;
          cnt_next_s   = 15'd1;
          idx_next_s   = 6'd39;
        end else begin
          cnt_next_s   = cnt_r + 15'd1;
        end
      end
      BIT_LO: begin
        if (cnt_r >= BIT_LOW_C) begin
          state_next_s = BIT_HI;
          cnt_next_s   = 15'd1;
        end else begin
          cnt_next_s   = cnt_r + 15'd1;
        end
      end
      BIT_HI: begin
        if (cnt_r >= (frame_r[idx_r] ? BIT1_HIGH_C : BIT0_HIGH_C)) begin
          cnt_next_s = 15'd1;
          if (idx_r == 6'd0) begin
            state_next_s = END_LO;
          end else begin
            state_next_s = BIT_LO;
            idx_next_s   = idx_r - 6'd1;
          end
        end else begin
          cnt_next_s = cnt_r + 15'd1;
        end
      end
      END_LO: begin
        if (cnt_r >= BIT_LOW_C) begin
          state_next_s = FINISH;
          cnt_next_s   = 15'd0;
        end else begin
          cnt_next_s   = cnt_r + 15'd1;
        end
      end
      FINISH: begin
        state_next_s = IDLE;
        cnt_next_s   = 15'd0;
      end
      default: begin
        state_next_s = IDLE;
        cnt_next_s   = 15'd0;
        idx_next_s   = 6'd0;
      end
    endcase
  end

  // State, frame latch and registered outputs decoded from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      cnt_r       <= 15'd0;
      idx_r       <= 6'd0;
      frame_r     <= 40'd0;
      dht_oe      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      short_start <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      cnt_r       <= cnt_next_s;
      idx_r       <= idx_next_s;
      dht_oe      <= (state_next_s inside {RESP_LO, BIT_LO, END_LO});
      busy        <= (state_next_s inside {RESP_WAIT, RESP_LO, RESP_HI, BIT_LO, BIT_HI, END_LO});
      done        <= (state_next_s == FINISH);
      short_start <= short_s;
      if (latch_s) begin
        frame_r <= {hum_int, hum_float, temp_int, temp_float,
                    frame_checksum(hum_int, hum_float, temp_int, temp_float, bad_checksum)};
      end
    end
  end

endmodule
